// File: rtl/seg_scanner_pkg.sv
// Shared defaults for the seven-segment scanner.
// Board defaults: 4 digits, 1 kHz per digit at 100 MHz.
package seg_scanner_pkg;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_REFRESH_DIV = 100000;

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scanner_refresh_tick.sv
// refresh_tick: free-running divider, tick on terminal count.
// Ports: clk, reset (async high), tick (1 cycle every DIV clocks).
module refresh_tick
  import seg_scanner_pkg::*;
#(
  parameter int DIV = DEF_REFRESH_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = idx_w(DIV);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexed 7-seg digit scanner with
// tear-free frame latch, per-digit blanking, zero suppression.
// Ports: clk, reset (async high), value, load, blank_mask,
//   lz_suppress in; number, anode (low), digit_idx, frame_done out.
module seg_scanner
  import seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [4*NUM_DIGITS-1:0]         value,
  input  logic                            load,
  input  logic [NUM_DIGITS-1:0]           blank_mask,
  input  logic                            lz_suppress,
  output logic [3:0]                      number,
  output logic [NUM_DIGITS-1:0]           anode,
  output logic [idx_w(NUM_DIGITS)-1:0]    digit_idx,
  output logic                            frame_done
);

  localparam int IW = idx_w(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  logic [4*NUM_DIGITS-1:0] r_pending;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [IW-1:0]           r_idx;
  logic [3:0]              r_number;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_last;
  logic                    w_wrap;
  logic [IW-1:0]           w_next_idx;
  logic [4*NUM_DIGITS-1:0] w_active_nxt;
  logic                    w_zero_above;
  logic [NUM_DIGITS-1:0]   w_lz_dark;
  logic [3:0]              w_num_nxt;
  logic [NUM_DIGITS-1:0]   w_anode_nxt;

  refresh_tick #(
    .DIV (REFRESH_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  always_comb begin
    w_last       = (r_idx == IW'(NUM_DIGITS - 1));
    w_next_idx   = w_last ? '0 : r_idx + 1'b1;
    w_wrap       = w_tick & w_last;
    // A load on the wrap edge bypasses pending so it is not
    // delayed by a whole frame.
    w_active_nxt = w_wrap ? (load ? value : r_pending) : r_active;

    // Walk from the most significant digit down; a digit is a
    // leading zero while every nibble at or above it is zero.
    w_zero_above = 1'b1;
    w_lz_dark    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above & (w_active_nxt[4*i +: 4] == 4'h0);
      if (i > 0) begin
        w_lz_dark[i] = lz_suppress & w_zero_above;
      end
    end

    w_num_nxt   = '0;
    w_anode_nxt = ANODE_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_next_idx == IW'(i)) begin
        w_num_nxt      = w_active_nxt[4*i +: 4];
        w_anode_nxt[i] = blank_mask[i] | w_lz_dark[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending    <= '0;
      r_active     <= '0;
      r_idx        <= '0;
      r_number     <= '0;
      r_anode      <= ANODE_OFF;
      r_frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_pending <= value;
      end
      r_active     <= w_active_nxt;
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_idx    <= w_next_idx;
        r_number <= w_num_nxt;
        r_anode  <= w_anode_nxt;
      end
    end
  end

  assign number     = r_number;
  assign anode      = r_anode;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule
